// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state codes, master IDs and latency limit.
// Round-robin tie-breaking is selected by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Smallest read latency the WAIT counter can represent.
  localparam int MEM_LAT_MIN = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_port_arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: ties alternate via last owner; undefined: m0 always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       i_last_owner,
`endif
  input  logic       i_idle,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  always_comb begin
    o_winner = M0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req == 2'b11) begin
      o_winner = (i_last_owner == M0) ? M1 : M0;
    end else if (i_req[1]) begin
      o_winner = M1;
    end
`else
    if (!i_req[0] && i_req[1]) begin
      o_winner = M1;
    end
`endif
    o_gnt = 2'b00;
    if (i_idle && (i_req != 2'b00)) begin
      o_gnt[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single memory port: grant, issue, wait MEM_LAT, respond.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default build is fixed m0 priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Latencies below the minimum are clamped so the counter never starts at zero.
  localparam int LAT   = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN : MEM_LAT;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]             w_req;
  logic [1:0]             w_gnt;
  logic                   w_winner;
  logic                   w_idle;
  logic                   w_last_wait;
  logic                   w_sel_we;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic [1:0]             w_rvalid;
  logic [1:0][DATA_W-1:0] w_rdata;

  assign w_req       = {m1_req, m0_req};
  assign w_idle      = (r_state == ST_IDLE);
  assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == CNT_ONE);
  assign w_sel_we    = w_winner ? m1_we    : m0_we;
  assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  // Starts at m1 so m0 takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= M1;
    end else if (w_gnt != 2'b00) begin
      r_last_owner <= w_winner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .i_req        (w_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .i_last_owner (r_last_owner),
`endif
    .i_idle       (w_idle),
    .o_gnt        (w_gnt),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= M0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_state <= ST_ISSUE;
            r_owner <= w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_cnt   <= CNT_LOAD;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Each master keeps its own response register so the non-owner's data is untouched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_rdata <= '0;
      end else if (w_last_wait && (r_owner == 1'(gi))) begin
        r_rdata <= r_we ? '0 : mem_rdata;
      end
    end

    assign w_rdata[gi]  = r_rdata;
    assign w_rvalid[gi] = (r_state == ST_RESP) && (r_owner == 1'(gi));
  end

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = w_rvalid[0];
  assign m1_rvalid = w_rvalid[1];
  assign m0_rdata  = w_rdata[0];
  assign m1_rdata  = w_rdata[1];
  assign mem_en    = (r_state == ST_ISSUE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timing reference model.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_mem_port_arbiter;

  localparam int LAT    = 3;
  localparam int RESP_D = LAT + 2;
  localparam int OCC    = LAT + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory environment: read data appears LAT cycles after the mem_en cycle, noise otherwise.
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[11:0]] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state: one transaction occupies OCC cycles from its grant.
  bit          m_busy;
  int          t_gnt;
  bit          m_owner, m_we, m_fresh;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit          m_last;
`endif
  bit          exp_any, exp_win;

  bit          drv_reset;
  bit          drv_req [2];
  bit          drv_we  [2];
  logic [31:0] drv_addr [2];
  logic [31:0] drv_wdata [2];

  int gnt_cyc [$];
  bit gnt_who [$];
  int rv_cyc  [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got 0x%08h, want 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit ref_winner(input bit r0, input bit r1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (r0 && r1) return !m_last;
`endif
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fresh = 1; m_rdata[0] = '0; m_rdata[1] = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    m_last = 1'b1;
`endif
  endtask

  // One clock cycle: drive, check against the model, then advance the model across the edge.
  task automatic step();
    int d;
    reset = drv_reset;
    m0_req = drv_req[0]; m0_we = drv_we[0]; m0_addr = drv_addr[0]; m0_wdata = drv_wdata[0];
    m1_req = drv_req[1]; m1_we = drv_we[1]; m1_addr = drv_addr[1]; m1_wdata = drv_wdata[1];
    #1;
    if (m_busy && (cyc - t_gnt) >= OCC) m_busy = 0;
    d = m_busy ? (cyc - t_gnt) : -1;
    exp_any = !m_busy && (drv_req[0] || drv_req[1]);
    exp_win = ref_winner(drv_req[0], drv_req[1]);
    if (d == RESP_D) begin
      m_rdata[m_owner] = m_we ? 32'h0 : ref_mem[m_addr[11:0]];
      $display("txn cyc=%0d m%0d %s addr=0x%08h data=0x%08h", cyc, m_owner,
               m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : m_rdata[m_owner]);
    end
    check_eq("m0_gnt", 32'(m0_gnt), 32'(exp_any && !exp_win));
    check_eq("m1_gnt", 32'(m1_gnt), 32'(exp_any && exp_win));
    check_eq("mem_en", 32'(mem_en), 32'(d == 1));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("m0_rvalid", 32'(m0_rvalid), 32'(d == RESP_D && !m_owner));
    check_eq("m1_rvalid", 32'(m1_rvalid), 32'(d == RESP_D && m_owner));
    check_eq("m0_rdata", m0_rdata, m_rdata[0]);
    check_eq("m1_rdata", m1_rdata, m_rdata[1]);
    if (d >= 1) begin
      check_eq("mem_we", 32'(mem_we), 32'(m_we));
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_wdata", mem_wdata, m_wdata);
    end else if (m_fresh) begin
      check_eq("rst_mem_we", 32'(mem_we), 32'h0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    end
    if (m0_gnt || m1_gnt) begin gnt_cyc.push_back(cyc); gnt_who.push_back(m1_gnt); end
    if (m0_rvalid || m1_rvalid) rv_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (drv_reset) begin
      model_reset();
    end else if (exp_any) begin
      m_busy = 1; t_gnt = cyc; m_owner = exp_win; m_fresh = 0;
      m_we = drv_we[exp_win]; m_addr = drv_addr[exp_win]; m_wdata = drv_wdata[exp_win];
      if (m_we) ref_mem[m_addr[11:0]] = m_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last = exp_win;
`endif
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic new_req(input bit m);
    drv_req[m] = 1; drv_we[m] = 1'($urandom_range(0, 1));
    drv_addr[m] = 32'h100 + 32'($urandom_range(0, 15) << 2);
    drv_wdata[m] = $urandom;
  endtask

  task automatic do_access(input bit m, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, output int g);
    drv_req[m] = 1; drv_we[m] = we; drv_addr[m] = a; drv_wdata[m] = wd;
    g = -1;
    for (int n = 0; n < 50 && g < 0; n++) begin
      step();
      if (exp_any && exp_win == m) g = cyc - 1;
    end
    drv_req[m] = 0;
    check_eq("gnt_seen", 32'(g >= 0), 32'h1);
  endtask

  initial begin
    int g;
    int n_m1;
    bit tie_exp [4];
    bit granted [2];
    logic [31:0] v;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    tie_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4096; i++) begin
      v = $urandom; mem[i] <= v; ref_mem[i] = v;
    end
    mem[12'h100] <= 32'hDEADBEEF; ref_mem[12'h100] = 32'hDEADBEEF;
    for (int m = 0; m < 2; m++) begin
      drv_req[m] = 0; drv_we[m] = 0; drv_addr[m] = '0; drv_wdata[m] = '0;
    end

    // First reset edge brings the DUT to a known state before any checks.
    drv_reset = 1;
    reset = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    @(posedge clk); #1;
    model_reset();
    run(2);
    drv_reset = 0;
    run(2);

    // Single read of a preloaded word.
    rv_cyc.delete();
    do_access(1'b0, 1'b0, 32'h100, 32'h0, g);
    run(OCC);
    check_eq("rd_rvalid_count", 32'(rv_cyc.size()), 32'h1);
    if (rv_cyc.size() > 0) check_eq("rd_latency", 32'(rv_cyc[0] - g), 32'(RESP_D));
    check_eq("rd_data", m0_rdata, 32'hDEADBEEF);

    // Write acknowledged through rvalid with zero data.
    do_access(1'b1, 1'b1, 32'h20, 32'h1234, g);
    run(OCC);
    check_eq("wr_mem", mem[12'h20], 32'h1234);
    check_eq("wr_ack_rdata", m1_rdata, 32'h0);

    // Both masters request continuously for four grants.
    gnt_cyc.delete(); gnt_who.delete(); rv_cyc.delete();
    new_req(1'b0); new_req(1'b1);
    for (int n = 0; n < 100 && gnt_cyc.size() < 4; n++) begin
      step();
      if (exp_any) new_req(exp_win);
    end
    drv_req[0] = 0; drv_req[1] = 0;
    run(OCC);
    check_eq("tie_count", 32'(gnt_cyc.size()), 32'h4);
    for (int i = 0; i < 4 && i < gnt_cyc.size(); i++) begin
      check_eq($sformatf("tie_gnt%0d", i), 32'(gnt_who[i]), 32'(tie_exp[i]));
      if (i > 0) check_eq("gnt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'(OCC));
      if (i < rv_cyc.size()) check_eq("rvalid_lat", 32'(rv_cyc[i] - gnt_cyc[i]), 32'(RESP_D));
    end

    // Reset during WAIT aborts the access.
    do_access(1'b0, 1'b0, 32'h104, 32'h0, g);
    run(2);
    rv_cyc.delete();
    drv_reset = 1;
    step();
    drv_reset = 0;
    check_eq("rst_mid_mem_en", 32'(mem_en), 32'h0);
    check_eq("rst_mid_busy", 32'(busy), 32'h0);
    check_eq("rst_mid_rvalid", 32'(m0_rvalid), 32'h0);
    run(OCC);
    check_eq("rst_no_rvalid", 32'(rv_cyc.size()), 32'h0);
    do_access(1'b0, 1'b0, 32'h100, 32'h0, g);
    run(OCC);
    check_eq("post_rst_read", 32'(rv_cyc.size()), 32'h1);

    // m1 pulses req while busy and withdraws.
    do_access(1'b0, 1'b0, 32'h108, 32'h0, g);
    gnt_who.delete(); gnt_cyc.delete();
    new_req(1'b1);
    step();
    drv_req[1] = 0;
    run(OCC + 2);
    n_m1 = 0;
    foreach (gnt_who[i]) if (gnt_who[i]) n_m1++;
    check_eq("withdraw_no_gnt", 32'(n_m1), 32'h0);

    // Random traffic with occasional withdrawals and resets.
    granted[0] = 0; granted[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (granted[m]) begin
          if ($urandom_range(0, 1) == 1) new_req(1'(m)); else drv_req[m] = 0;
        end else if (drv_req[m]) begin
          if ($urandom_range(0, 15) == 0) drv_req[m] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(1'(m));
        end
      end
      drv_reset = ($urandom_range(0, 299) == 0);
      if (drv_reset) begin drv_req[0] = 0; drv_req[1] = 0; end
      step();
      granted[0] = exp_any && !exp_win;
      granted[1] = exp_any && exp_win;
    end
    drv_reset = 0; drv_req[0] = 0; drv_req[1] = 0;
    run(OCC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port of the multicycle core between two masters: m0 (core fetch/load/store path) and m1 (program loader / debug master). Each transaction runs a fixed sequence: grant, issue, wait for read latency, respond. The block sits between the core's address mux and the memory array and replaces the direct core-to-memory connection.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is valid; legal range is ≥1

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  request; held until the matching gnt is seen
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  one-cycle grant; request fields are captured on this edge
- m0_rvalid / m1_rvalid  out  1  one-cycle response: read data valid, or write acknowledge
- m0_rdata / m1_rdata  out  DATA_W  registered read data; 0 for writes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: if any req is high, assert gnt to the winner, capture we/addr/wdata and the owner ID, then go to ISSUE.
  - ISSUE: `mem_en`=1, `mem_we`=captured we. Go to WAIT.
  - WAIT: count MEM_LAT cycles. In the last one, capture `mem_rdata`, or 0 if the transaction is a write. Go to RESP.
  - RESP: the owner's rvalid=1 and its rdata holds the captured value. Go to IDLE.
- Arbitration applies only in IDLE. gnt is combinational from req and state, and is never high outside IDLE.
- The non-owner's rvalid is 0; its rdata holds its last value.
- A req that drops before gnt produces no transaction.
- A req still high in the cycle after gnt counts as a new request; the requester must drop req after gnt unless it wants another access.
- The WAIT counter is $clog2(MEM_LAT+1) bits wide. It loads in ISSUE and decrements to 0. There is no wrap.
- A write still passes through WAIT and RESP. rvalid then serves as the write acknowledge so the core FSM can sequence stores uniformly.

## Timing
- Cycle 0: gnt (IDLE).
- Cycle 1: `mem_en` (ISSUE).
- Cycles 2..MEM_LAT+1: WAIT.
- Cycle MEM_LAT+2: rvalid.
- Next grant no earlier than cycle MEM_LAT+3, so occupancy is MEM_LAT+3 cycles per access.
- Reset values:
  - state IDLE
  - all gnt, rvalid, `mem_en`, `mem_we`, busy = 0
  - `mem_addr`, `mem_wdata`, m0_rdata, m1_rdata = 0
  - last-owner = m1, so m0 wins the first tie
- Reset asserted mid-transaction aborts it. No rvalid is produced, and `mem_en` is 0 from the cycle after the reset edge.
- Simultaneous m0_req and m1_req in IDLE: exactly one gnt, following the Configuration rule.
- `mem_addr`/`mem_we`/`mem_wdata` stay stable from ISSUE through RESP.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the master that was not granted last. Last-owner updates on every grant.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, m0 always wins a tie. m1 can starve while the core issues back-to-back requests. The last-owner register is removed.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - master ID constants (M0=0, M1=1)
  - MEM_LAT lower-bound check constant
- Sub-module `mem_arb_pick`: combinational winner selection from req[1:0], last-owner and idle. Outputs gnt[1:0] and winner ID, and contains the macro-dependent logic.
- Top level holds the FSM, WAIT counter, request capture and response registers.

## Test plan
- Single read: MEM_LAT=1; m0 reads 0x100 where memory holds 0xDEADBEEF. Expect m0_gnt at cycle 0, `mem_en` at cycle 1 with `mem_we`=0, and m0_rvalid with m0_rdata=0xDEADBEEF at cycle 3.
- Write ack: m1 writes 0x0000_1234 to 0x20. Expect `mem_we`=1 in ISSUE, memory[0x20]=0x1234 afterwards, and m1_rvalid with m1_rdata=0.
- Tie with MEM_ARB_ROUND_ROBIN_EN: both masters request continuously for 4 transactions. Grants must go m0, m1, m0, m1. Without the macro, all 4 go to m0.
- Latency sweep: MEM_LAT=3. rvalid must arrive exactly 5 cycles after gnt, and the next gnt exactly 6 cycles after the previous one.
- Reset mid-operation: assert reset during WAIT. No rvalid, `mem_en`=0, busy=0 in the next cycle. After reset is released, a fresh m0 read completes normally.
- Request withdrawal: m1_req is high for one cycle while the block is busy, then drops. No m1_gnt is ever issued.
